// File: rtl/modular_multiply.sv
// Sequential interleaved shift-and-add modular multiplier: Out = (A * B) mod P,
// one multiplier bit per clock, MSB first, with a Start/Done level handshake.
module modular_multiply #(
    parameter int              W = 16,
    parameter logic [W-1:0]    P = 16'hFC2F
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Out,
    output logic         Busy,
    output logic         Done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REDUCE = 2'd1;
    localparam logic [1:0] S_MULT   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    // Modulus and twice the modulus widened so the compares see the full sum.
    localparam logic [W+1:0] P_X  = {2'b00, P};
    localparam logic [W+1:0] P2_X = {1'b0, P, 1'b0};

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W+1:0]  mult_sum;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        // 2R + (bit ? A : 0); bounded by 3P-3 since R < P and A < P.
        mult_sum = {1'b0, r_q, 1'b0} + (b_q[cnt_q] ? {2'b00, a_q} : '0);

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    r_d     = '0;
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                // Inputs are below 2^W < 2P, so a single subtraction suffices.
                if (a_q >= P) a_d = a_q - P;
                if (b_q >= P) b_d = b_q - P;
                cnt_d   = CW'(W - 1);
                state_d = S_MULT;
            end
            S_MULT: begin
                if (mult_sum >= P2_X) begin
                    r_d = W'(mult_sum - P2_X);
                end else if (mult_sum >= P_X) begin
                    r_d = W'(mult_sum - P_X);
                end else begin
                    r_d = W'(mult_sum);
                end
                if (cnt_q == '0) begin
                    out_d   = r_d;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FINISH: begin
                if (!Start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Out  = out_q;
    assign Busy = (state_q == S_REDUCE) || (state_q == S_MULT);
    assign Done = (state_q == S_FINISH);

endmodule

// File: tb/tb_modular_multiply.sv
// Self-checking bench for modular_multiply: expected products are queued when a
// request is issued and compared against Out once Done rises.
module tb_modular_multiply;

    localparam int          W = 16;
    localparam logic [15:0] P = 16'hFC2F;
    localparam int          TIMEOUT = 100;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Out;
    logic         Busy;
    logic         Done;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    modular_multiply #(.W(W), .P(P)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Out   (Out),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned prod;
        prod = longint'(a) * longint'(b);
        return W'(prod % longint'(P));
    endfunction

    // Issue a request at a falling edge and queue the expected product.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        A     = a;
        B     = b;
        Start = 1'b1;
        exp_q.push_back(model(a, b));
    endtask

    // Counts edges (the accepting edge is edge 1) until Done; also counts Busy cycles.
    task automatic wait_done(output int edges, output int busy_cycles, output bit timed_out);
        edges       = 0;
        busy_cycles = 0;
        timed_out   = 1'b1;
        for (int n = 0; n < TIMEOUT; n++) begin
            @(posedge Clk);
            #1;
            edges++;
            if (Busy) busy_cycles++;
            if (Done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic pop_expected(output logic [W-1:0] exp_v);
        if (exp_q.size() == 0) exp_v = 'x;
        else exp_v = exp_q.pop_front();
    endtask

    task automatic release_start();
        @(negedge Clk);
        Start = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (Out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", Out); end
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++;
        if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
        @(negedge Clk);
        Reset = 1'b1;
        $display("reset: Out=%h Busy=%b Done=%b", Out, Busy, Done);
    endtask

    task automatic test_basic();
        int edges, busy_cycles;
        bit to;
        logic [W-1:0] exp_v;
        start_op(16'd3, 16'd5);
        wait_done(edges, busy_cycles, to);
        pop_expected(exp_v);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout: no Done within %0d cycles", TIMEOUT); end
        checks++;
        if (edges != W + 2) begin errors++; $display("FAIL basic_latency: got %0d want %0d", edges, W + 2); end
        checks++;
        if (busy_cycles != W + 1) begin errors++; $display("FAIL basic_busy: got %0d want %0d", busy_cycles, W + 1); end
        checks++;
        if (Out !== 16'h000F || exp_v !== 16'h000F) begin
            errors++; $display("FAIL basic_out: got %h want 000f (model %h)", Out, exp_v);
        end
        $display("basic: A=3 B=5 Out=%h latency=%0d busy=%0d", Out, edges, busy_cycles);
        release_start();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got Done=%b Busy=%b want 0 0", Done, Busy);
        end
    endtask

    // Directed vectors: zero operands, inverse pairs, input reduction.
    task automatic test_directed();
        logic [W-1:0] va [7] = '{16'h0000, 16'h1234, 16'h0002, 16'hFC2E, 16'hFFFF, 16'hFC2F, 16'h0004};
        logic [W-1:0] vb [7] = '{16'h1234, 16'h0000, 16'h7E18, 16'hFC2E, 16'h0001, 16'hABCD, 16'h0004};
        logic [W-1:0] vr [7] = '{16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h03D0, 16'h0000, 16'h0010};
        int edges, busy_cycles;
        bit to;
        logic [W-1:0] exp_v;
        for (int k = 0; k < 7; k++) begin
            start_op(va[k], vb[k]);
            wait_done(edges, busy_cycles, to);
            pop_expected(exp_v);
            checks++;
            if (to) begin errors++; $display("FAIL directed_timeout[%0d]: no Done", k); end
            checks++;
            if (Out !== vr[k] || exp_v !== vr[k]) begin
                errors++; $display("FAIL directed_out[%0d]: A=%h B=%h got %h want %h (model %h)", k, va[k], vb[k], Out, vr[k], exp_v);
            end
            $display("directed: A=%h B=%h Out=%h", va[k], vb[k], Out);
            release_start();
        end
    endtask

    task automatic test_handshake();
        int edges, busy_cycles;
        bit to;
        bit stayed;
        logic [W-1:0] exp_v;
        start_op(16'h0007, 16'h0009);
        wait_done(edges, busy_cycles, to);
        pop_expected(exp_v);
        checks++;
        if (to || Out !== 16'h003F) begin errors++; $display("FAIL hs_first: got %h want 003f", Out); end
        // Start stays high: block must sit in Finish and never restart.
        stayed = 1'b1;
        for (int n = 0; n < 3 * W; n++) begin
            @(posedge Clk);
            #1;
            if (Done !== 1'b1 || Busy !== 1'b0 || Out !== exp_v) stayed = 1'b0;
        end
        checks++;
        if (!stayed) begin errors++; $display("FAIL hs_hold: got Done=%b Busy=%b Out=%h want 1 0 %h", Done, Busy, Out, exp_v); end
        release_start();
        checks++;
        if (Done !== 1'b0) begin errors++; $display("FAIL hs_drop: got Done=%b want 0", Done); end
        start_op(16'h0004, 16'h0004);
        wait_done(edges, busy_cycles, to);
        pop_expected(exp_v);
        checks++;
        if (to || Out !== 16'h0010 || exp_v !== 16'h0010) begin
            errors++; $display("FAIL hs_restart: got %h want 0010", Out);
        end
        $display("handshake: hold ok=%0b restart Out=%h", stayed, Out);
        release_start();
    endtask

    task automatic test_reset_mid();
        int edges, busy_cycles;
        bit to;
        logic [W-1:0] exp_v;
        @(negedge Clk);
        A     = 16'h1111;
        B     = 16'h2222;
        Start = 1'b1;
        // Accept edge, Reduce edge, then six Mult edges: now in Mult cycle 7.
        repeat (8) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b want 1", Busy); end
        Reset = 1'b0;
        Start = 1'b0;
        @(posedge Clk);
        #1;
        checks++;
        if (Out !== 16'h0000 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got Out=%h Busy=%b Done=%b want 0000 0 0", Out, Busy, Done);
        end
        @(negedge Clk);
        Reset = 1'b1;
        start_op(16'd3, 16'd5);
        wait_done(edges, busy_cycles, to);
        pop_expected(exp_v);
        checks++;
        if (to || Out !== 16'h000F || edges != W + 2) begin
            errors++; $display("FAIL rst_mid_rerun: got %h latency %0d want 000f %0d", Out, edges, W + 2);
        end
        $display("reset_mid: rerun Out=%h", Out);
        release_start();
    endtask

    task automatic test_random();
        int edges, busy_cycles;
        bit to;
        logic [W-1:0] exp_v, a, b;
        int bad = 0;
        for (int k = 0; k < 1000; k++) begin
            a = W'($urandom_range(0, 65535));
            b = W'($urandom_range(0, 65535));
            if (k % 4 == 1) a = W'($urandom_range(int'(P), 65535));
            if (k % 4 == 2) b = W'($urandom_range(int'(P), 65535));
            start_op(a, b);
            wait_done(edges, busy_cycles, to);
            pop_expected(exp_v);
            checks++;
            if (to || Out !== exp_v || Out >= P) begin
                errors++; bad++;
                $display("FAIL random[%0d]: A=%h B=%h got %h want %h", k, a, b, Out, exp_v);
            end
            $display("random[%0d]: A=%h B=%h Out=%h", k, a, b, Out);
            release_start();
        end
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        test_reset();
        test_basic();
        test_directed();
        test_handshake();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
